// File: rtl/npu_mmio_pkg.sv
// Shared definitions for the NPU control register file: register map, control
// and status bit positions, and the host-side sequencer state encoding.
package npu_mmio_pkg;

  localparam logic [7:0] REG_CTRL        = 8'h00;
  localparam logic [7:0] REG_STATUS      = 8'h04;
  localparam logic [7:0] REG_PROMPT_LEN  = 8'h08;
  localparam logic [7:0] REG_GEN_LEN     = 8'h0C;
  localparam logic [7:0] REG_DONE_TOKENS = 8'h10;
  localparam logic [7:0] REG_LAST_ERROR  = 8'h14;
  localparam logic [7:0] REG_PERF_CYCLES = 8'h18;
  localparam logic [7:0] REG_PERF_TOKENS = 8'h1C;
  localparam logic [7:0] REG_STALL_IN    = 8'h20;
  localparam logic [7:0] REG_STALL_OUT   = 8'h24;
  localparam logic [7:0] REG_K_TILE      = 8'h28;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_RESET_BIT = 1;

  localparam logic [31:0] STATUS_BUSY  = 32'h0000_0001;
  localparam logic [31:0] STATUS_DONE  = 32'h0000_0002;
  localparam logic [31:0] STATUS_ERROR = 32'h0000_0004;

  // Readback covers the six consecutive counter registers starting at DONE_TOKENS.
  localparam logic [2:0] RB_LAST_IDX = 3'd5;

  typedef enum logic [3:0] {
    HS_IDLE      = 4'd0,
    HS_WR_PROMPT = 4'd1,
    HS_WR_GEN    = 4'd2,
    HS_WR_KTILE  = 4'd3,
    HS_WR_START  = 4'd4,
    HS_RD_STATUS = 4'd5,
    HS_POLL_WAIT = 4'd6,
    HS_READBACK  = 4'd7,
    HS_ABORT     = 4'd8,
    HS_RESP      = 4'd9
  } host_state_e;

  function automatic logic [7:0] rb_addr(input logic [2:0] idx);
    return REG_DONE_TOKENS + {3'd0, idx, 2'd0};
  endfunction

endpackage

// File: rtl/npu_mmio_host_seq.sv
// Host-side MMIO initiator: programs one NPU job, polls STATUS until done,
// error or timeout, then reads back the counters onto a valid/ready result port.
module npu_mmio_host_seq
  import npu_mmio_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 8,
  parameter int unsigned POLL_GAP       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_prompt_len,
  input  logic [31:0]           cmd_gen_len,
  input  logic [31:0]           cmd_k_tile,
  output logic                  mmio_wr_en,
  output logic                  mmio_rd_en,
  output logic [ADDR_WIDTH-1:0] mmio_addr,
  output logic [31:0]           mmio_wdata,
  input  logic [31:0]           mmio_rdata,
  input  logic                  mmio_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_status,
  output logic                  res_timeout,
  output logic [31:0]           res_done_tokens,
  output logic [31:0]           res_last_error,
  output logic [31:0]           res_perf_cycles,
  output logic [31:0]           res_perf_tokens,
  output logic [31:0]           res_stall_in,
  output logic [31:0]           res_stall_out,
  output logic                  busy,
  output logic [3:0]            dbg_state
);

  // Handshakes: cmd and res transfer on a clock edge where valid && ready;
  // an MMIO request (wr_en or rd_en) holds addr/wdata until the edge where
  // mmio_ready is also high, and the next request may start on that same edge.

  host_state_e  state;
  logic [31:0]  gen_q;
  logic [31:0]  ktile_q;
  logic [2:0]   rb_idx;
  logic [15:0]  gap_cnt;
  logic [31:0]  tmo_cnt;
  logic         mmio_done;
  logic         timed_out;

  function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [7:0] a);
    return ADDR_WIDTH'(a);
  endfunction

  assign mmio_done = (mmio_wr_en | mmio_rd_en) & mmio_ready;
  assign timed_out = (tmo_cnt >= 32'(TIMEOUT_CYCLES));
  assign cmd_ready = (state == HS_IDLE);
  assign busy      = (state != HS_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= HS_IDLE;
      gen_q           <= '0;
      ktile_q         <= '0;
      rb_idx          <= '0;
      gap_cnt         <= '0;
      tmo_cnt         <= '0;
      mmio_wr_en      <= 1'b0;
      mmio_rd_en      <= 1'b0;
      mmio_addr       <= '0;
      mmio_wdata      <= '0;
      res_valid       <= 1'b0;
      res_status      <= '0;
      res_timeout     <= 1'b0;
      res_done_tokens <= '0;
      res_last_error  <= '0;
      res_perf_cycles <= '0;
      res_perf_tokens <= '0;
      res_stall_in    <= '0;
      res_stall_out   <= '0;
    end else begin
      // The abort deadline only runs while waiting on the NPU.
      if ((state == HS_RD_STATUS || state == HS_POLL_WAIT) && tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 32'd1;

      case (state)
        HS_IDLE: begin
          if (cmd_valid) begin
            gen_q           <= cmd_gen_len;
            ktile_q         <= cmd_k_tile;
            res_status      <= '0;
            res_timeout     <= 1'b0;
            res_done_tokens <= '0;
            res_last_error  <= '0;
            res_perf_cycles <= '0;
            res_perf_tokens <= '0;
            res_stall_in    <= '0;
            res_stall_out   <= '0;
            mmio_wr_en      <= 1'b1;
            mmio_addr       <= to_addr(REG_PROMPT_LEN);
            mmio_wdata      <= cmd_prompt_len;
            state           <= HS_WR_PROMPT;
          end
        end

        HS_WR_PROMPT: begin
          if (mmio_done) begin
            mmio_addr  <= to_addr(REG_GEN_LEN);
            mmio_wdata <= gen_q;
            state      <= HS_WR_GEN;
          end
        end

        HS_WR_GEN: begin
          if (mmio_done) begin
            mmio_addr  <= to_addr(REG_K_TILE);
            mmio_wdata <= ktile_q;
            state      <= HS_WR_KTILE;
          end
        end

        HS_WR_KTILE: begin
          if (mmio_done) begin
            mmio_addr  <= to_addr(REG_CTRL);
            mmio_wdata <= 32'd1 << CTRL_START_BIT;
            state      <= HS_WR_START;
          end
        end

        HS_WR_START: begin
          if (mmio_done) begin
            mmio_wr_en <= 1'b0;
            mmio_rd_en <= 1'b1;
            mmio_addr  <= to_addr(REG_STATUS);
            mmio_wdata <= '0;
            tmo_cnt    <= '0;
            state      <= HS_RD_STATUS;
          end
        end

        HS_RD_STATUS: begin
          if (mmio_done) begin
            res_status <= mmio_rdata;
            if ((mmio_rdata & (STATUS_DONE | STATUS_ERROR)) != '0) begin
              rb_idx    <= '0;
              mmio_addr <= to_addr(REG_DONE_TOKENS);
              state     <= HS_READBACK;
            end else if (timed_out) begin
              mmio_rd_en <= 1'b0;
              mmio_wr_en <= 1'b1;
              mmio_addr  <= to_addr(REG_CTRL);
              mmio_wdata <= 32'd1 << CTRL_RESET_BIT;
              state      <= HS_ABORT;
            end else if (POLL_GAP == 0) begin
              state <= HS_RD_STATUS;
            end else begin
              mmio_rd_en <= 1'b0;
              gap_cnt    <= '0;
              state      <= HS_POLL_WAIT;
            end
          end
        end

        HS_POLL_WAIT: begin
          if (timed_out) begin
            mmio_wr_en <= 1'b1;
            mmio_addr  <= to_addr(REG_CTRL);
            mmio_wdata <= 32'd1 << CTRL_RESET_BIT;
            state      <= HS_ABORT;
          end else if (gap_cnt == 16'(POLL_GAP - 1)) begin
            mmio_rd_en <= 1'b1;
            state      <= HS_RD_STATUS;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        HS_READBACK: begin
          if (mmio_done) begin
            case (rb_idx)
              3'd0:    res_done_tokens <= mmio_rdata;
              3'd1:    res_last_error  <= mmio_rdata;
              3'd2:    res_perf_cycles <= mmio_rdata;
              3'd3:    res_perf_tokens <= mmio_rdata;
              3'd4:    res_stall_in    <= mmio_rdata;
              default: res_stall_out   <= mmio_rdata;
            endcase
            if (rb_idx == RB_LAST_IDX) begin
              mmio_rd_en <= 1'b0;
              mmio_addr  <= '0;
              res_valid  <= 1'b1;
              state      <= HS_RESP;
            end else begin
              rb_idx    <= rb_idx + 3'd1;
              mmio_addr <= to_addr(rb_addr(rb_idx + 3'd1));
            end
          end
        end

        HS_ABORT: begin
          if (mmio_done) begin
            mmio_wr_en  <= 1'b0;
            mmio_addr   <= '0;
            mmio_wdata  <= '0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= HS_RESP;
          end
        end

        HS_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= HS_IDLE;
          end
        end

        default: state <= HS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_mmio_host_seq.sv
// Bench for npu_mmio_host_seq: scripted NPU slave with random ready delay and
// a job-level reference of the expected MMIO traffic and result fields.
module tb_npu_mmio_host_seq;
  import npu_mmio_pkg::*;

  localparam int AW  = 8;
  localparam int GAP = 2;
  localparam int TMO = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_prompt_len = '0, cmd_gen_len = '0, cmd_k_tile = '0;
  logic          mmio_wr_en, mmio_rd_en;
  logic [AW-1:0] mmio_addr;
  logic [31:0]   mmio_wdata;
  logic [31:0]   mmio_rdata = '0;
  logic          mmio_ready = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_status;
  logic          res_timeout;
  logic [31:0]   res_done_tokens, res_last_error, res_perf_cycles;
  logic [31:0]   res_perf_tokens, res_stall_in, res_stall_out;
  logic          busy;
  logic [3:0]    dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  npu_mmio_host_seq #(.ADDR_WIDTH(AW), .POLL_GAP(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_prompt_len(cmd_prompt_len), .cmd_gen_len(cmd_gen_len), .cmd_k_tile(cmd_k_tile),
    .mmio_wr_en(mmio_wr_en), .mmio_rd_en(mmio_rd_en), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
    .res_timeout(res_timeout), .res_done_tokens(res_done_tokens),
    .res_last_error(res_last_error), .res_perf_cycles(res_perf_cycles),
    .res_perf_tokens(res_perf_tokens), .res_stall_in(res_stall_in),
    .res_stall_out(res_stall_out), .busy(busy), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // slave configuration, written only by the stimulus process
  int          cfg_busy  = 0;
  logic [31:0] cfg_final = STATUS_DONE;
  int          cfg_delay = 0;
  logic [31:0] cnt_regs[6];

  // slave observation state, written only by the slave process
  int            cyc = 0;
  int            first_status_cyc = 0;
  int            status_reads = 0;
  bit            aborted = 0, stable_ok = 1, onehot_ok = 1;
  bit            pending = 0, gap_track = 0;
  int            wait_left = 0, gap_run = 0, gap_min = 1000, gap_max = -1;
  logic [AW-1:0] p_addr;
  logic [31:0]   p_wdata;
  logic          p_wr, p_rd;
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  logic [AW-1:0] rd_addr_q[$];

  function automatic logic [31:0] slave_read(input logic [AW-1:0] a);
    if (a == AW'(REG_STATUS))
      return aborted ? 32'd0 : (status_reads < cfg_busy ? STATUS_BUSY : cfg_final);
    if (a >= AW'(REG_DONE_TOKENS) && a <= AW'(REG_STALL_OUT))
      return cnt_regs[(a - AW'(REG_DONE_TOKENS)) >> 2];
    return 32'd0;
  endfunction

  // NPU slave: decides ready/rdata on the falling edge, logs completions on the rising edge
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      cyc++;
      if (!rst_n) begin
        pending = 0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
          status_reads = 0; aborted = 0; stable_ok = 1; onehot_ok = 1;
          gap_track = 0; gap_min = 1000; gap_max = -1;
        end
        if ((mmio_wr_en || mmio_rd_en) && mmio_ready) begin
          pending = 0;
          if (mmio_wr_en) begin
            wr_addr_q.push_back(mmio_addr);
            wr_data_q.push_back(mmio_wdata);
            if (mmio_addr == AW'(REG_CTRL) && mmio_wdata[CTRL_RESET_BIT]) aborted = 1;
          end else if (mmio_addr == AW'(REG_STATUS)) begin
            if (status_reads == 0) first_status_cyc = cyc;
            if (!aborted && status_reads < cfg_busy) begin
              gap_track = 1;
              gap_run = 0;
            end
            status_reads++;
          end else begin
            rd_addr_q.push_back(mmio_addr);
          end
        end
      end
    end else begin
      if (!rst_n) begin
        pending = 0; mmio_ready = 1'b0; gap_track = 0;
      end else if (mmio_wr_en || mmio_rd_en) begin
        if (mmio_wr_en && mmio_rd_en) onehot_ok = 0;
        if (gap_track) begin
          if (gap_run < gap_min) gap_min = gap_run;
          if (gap_run > gap_max) gap_max = gap_run;
          gap_track = 0;
        end
        if (!pending) begin
          pending = 1;
          wait_left = $urandom_range(0, cfg_delay);
          p_addr = mmio_addr; p_wdata = mmio_wdata; p_wr = mmio_wr_en; p_rd = mmio_rd_en;
        end else if (mmio_addr !== p_addr || mmio_wdata !== p_wdata ||
                     mmio_wr_en !== p_wr || mmio_rd_en !== p_rd) begin
          stable_ok = 0;
        end
        if (wait_left == 0) begin
          mmio_ready = 1'b1;
          mmio_rdata = slave_read(mmio_addr);
        end else begin
          mmio_ready = 1'b0;
          mmio_rdata = $urandom;
          wait_left--;
        end
      end else begin
        mmio_ready = 1'b0;
        mmio_rdata = $urandom;
        if (gap_track) gap_run++;
      end
    end
  end

  // driver: issue one command at the next idle edge
  task automatic send_cmd(input logic [31:0] p, input logic [31:0] g, input logic [31:0] k,
                          output int t_acc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_prompt_len = p; cmd_gen_len = g; cmd_k_tile = k;
    @(posedge clk);
    #1;
    t_acc = cyc;
    cmd_valid = 1'b0; cmd_prompt_len = $urandom; cmd_gen_len = $urandom; cmd_k_tile = $urandom;
  endtask

  // one job end to end; the expected results follow from the job description alone
  task automatic run_job(input logic [31:0] p, input logic [31:0] g, input logic [31:0] k,
                         input int nbusy, input logic [31:0] fin, input int dly,
                         input bit tmo, input int hold);
    logic [31:0] exp_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] exp_cnt[6];
    logic [31:0] got_cnt[6];
    logic [31:0] snap[8];
    int t_acc, guard;
    bit hold_ok;

    cfg_busy  = tmo ? 1000000 : nbusy;
    cfg_final = fin;
    cfg_delay = dly;
    exp_q   = '{32'(REG_PROMPT_LEN), 32'(REG_GEN_LEN), 32'(REG_K_TILE), 32'(REG_CTRL)};
    exp_d_q = '{p, g, k, 32'd1};
    if (tmo) begin
      exp_q.push_back(32'(REG_CTRL));
      exp_d_q.push_back(32'd2);
    end
    for (int i = 0; i < 6; i++) exp_cnt[i] = tmo ? 32'd0 : cnt_regs[i];

    send_cmd(p, g, k, t_acc);
    check("busy_after_cmd", 32'(busy), 32'd1);
    guard = 0;
    while (!res_valid && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("res_valid", 32'(res_valid), 32'd1);

    snap = '{res_status, 32'(res_timeout), res_done_tokens, res_last_error,
             res_perf_cycles, res_perf_tokens, res_stall_in, res_stall_out};
    hold_ok = 1;
    repeat (hold) begin
      @(negedge clk);
      if (!res_valid || cmd_ready || res_status !== snap[0] || 32'(res_timeout) !== snap[1] ||
          res_done_tokens !== snap[2] || res_last_error !== snap[3] ||
          res_perf_cycles !== snap[4] || res_perf_tokens !== snap[5] ||
          res_stall_in !== snap[6] || res_stall_out !== snap[7]) hold_ok = 0;
    end
    check("resp_hold_stable", 32'(hold_ok), 32'd1);

    check("res_status", res_status, tmo ? STATUS_BUSY : fin);
    check("res_timeout", 32'(res_timeout), 32'(tmo));
    got_cnt = '{res_done_tokens, res_last_error, res_perf_cycles,
                res_perf_tokens, res_stall_in, res_stall_out};
    for (int i = 0; i < 6; i++) check($sformatf("res_cnt%0d", i), got_cnt[i], exp_cnt[i]);

    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_resp", 32'(cmd_ready), 32'd1);
    check("res_valid_drop", 32'(res_valid), 32'd0);

    check("wr_count", 32'(wr_addr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < wr_addr_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("wr_addr%0d", i), 32'(wr_addr_q[i]), exp_q[i]);
      check($sformatf("wr_data%0d", i), wr_data_q[i], exp_d_q[i]);
    end
    if (tmo) begin
      check("tmo_status_polled", 32'(status_reads > 0), 32'd1);
      check("tmo_no_readback", 32'(rd_addr_q.size()), 32'd0);
    end else begin
      check("status_reads", 32'(status_reads), 32'(nbusy + 1));
      check("rb_count", 32'(rd_addr_q.size()), 32'd6);
      for (int i = 0; i < rd_addr_q.size() && i < 6; i++)
        check($sformatf("rb_addr%0d", i), 32'(rd_addr_q[i]), 32'(REG_DONE_TOKENS) + 32'(4 * i));
      if (nbusy > 0) begin
        check("poll_gap_min", 32'(gap_min), 32'(GAP));
        check("poll_gap_max", 32'(gap_max), 32'(GAP));
      end
    end
    if (dly == 0) check("first_status_latency", 32'(first_status_cyc - t_acc), 32'd5);
    check("mmio_stable", 32'(stable_ok), 32'd1);
    check("mmio_onehot", 32'(onehot_ok), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mmio_req"}, {30'd0, mmio_wr_en, mmio_rd_en}, 32'd0);
    check({tag, "_mmio_addr"}, 32'(mmio_addr), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_status"}, res_status, 32'd0);
    check({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    logic [31:0] fin_tab[4];
    int t_acc;
    fin_tab = '{STATUS_DONE, STATUS_ERROR, STATUS_DONE | STATUS_ERROR, STATUS_BUSY | STATUS_DONE};
    cnt_regs = '{default: 32'd0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // nominal job, then the k_tile stall variant, then an immediate error
    cnt_regs = '{32'd3, 32'd0, 32'd96, 32'd3, 32'd0, 32'd0};
    run_job(32'd5, 32'd3, 32'd16, 4, STATUS_DONE, 0, 1'b0, 1);
    cnt_regs = '{32'd3, 32'd0, 32'd96, 32'd3, 32'd96, 32'd0};
    run_job(32'd5, 32'd3, 32'd2, 4, STATUS_DONE, 0, 1'b0, 0);
    cnt_regs = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0};
    run_job(32'd0, 32'd4, 32'd16, 0, STATUS_ERROR, 0, 1'b0, 0);

    // slow slave, and a consumer that stalls the result
    cnt_regs = '{32'd3, 32'd0, 32'd96, 32'd3, 32'd0, 32'd0};
    run_job(32'd5, 32'd3, 32'd16, 4, STATUS_DONE, 3, 1'b0, 2);
    run_job(32'd5, 32'd3, 32'd16, 2, STATUS_DONE, 1, 1'b0, 10);

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 6; i++) cnt_regs[i] = $urandom;
      run_job($urandom, $urandom_range(0, 64), $urandom_range(1, 32), $urandom_range(0, 6),
              fin_tab[$urandom_range(0, 3)], $urandom_range(0, 3), 1'b0, $urandom_range(0, 3));
    end

    // NPU never finishes: abort path reports zeros despite nonzero slave counters
    cnt_regs = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55, 32'd66};
    run_job(32'd5, 32'd10, 32'd16, 0, STATUS_DONE, 0, 1'b1, 1);

    // reset in the middle of polling
    cfg_busy = 1000000; cfg_delay = 1;
    send_cmd(32'd7, 32'd9, 32'd4, t_acc);
    repeat (20) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    cnt_regs = '{32'd1, 32'd0, 32'd40, 32'd1, 32'd5, 32'd6};
    run_job(32'd2, 32'd1, 32'd8, 1, STATUS_DONE, 2, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
